// File: rtl/sram_wrap_pkg.sv
// Shared types and helpers for the 1w1r SRAM adapter: sweep state
// encoding, write-mask granule expansion and parameter legality checks.
// The optional post-reset clearing sweep is selected by SRAM_INIT_EN.
package sram_wrap_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sweep_state_e;

    // Upper bounds for the generic mask-expansion helper below.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_MASK_W = 64;

    // Expand one bit per granule into one bit per data bit. Bits above
    // data_w are returned as zero; callers truncate to their own width.
    function automatic logic [MAX_DATA_W-1:0] expand_mask(
        input logic [MAX_MASK_W-1:0] mask,
        input int                    data_w,
        input int                    mask_w
    );
        logic [MAX_DATA_W-1:0] expanded;
        logic [7:0]            bit_idx;
        logic [5:0]            gran_idx;
        int                    gran_w;
        expanded = '0;
        gran_w   = ((mask_w > 0) && (data_w >= mask_w)) ? (data_w / mask_w) : 1;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            bit_idx  = 8'(i);
            gran_idx = 6'(i / gran_w);
            if (i < data_w) begin
                expanded[bit_idx] = mask[gran_idx];
            end
        end
        return expanded;
    endfunction

    // True when the geometry can be built: the array fits the address
    // space and the word splits evenly into mask granules.
    function automatic bit params_ok(
        input int addr_w,
        input int depth,
        input int data_w,
        input int mask_w
    );
        return (addr_w >= 1) && (addr_w <= 30) &&
               (depth >= 1) && (depth <= (1 << addr_w)) &&
               (mask_w >= 1) && (mask_w <= MAX_MASK_W) &&
               (data_w >= mask_w) && (data_w <= MAX_DATA_W) &&
               ((data_w % mask_w) == 0);
    endfunction

endpackage

// File: rtl/sram_init_sweeper.sv
// Post-reset clearing sweep for the 1w1r SRAM adapter. Owns the sweep
// counter, the INIT/READY state and the ready flag, and muxes the macro
// write port between the sweep and the upstream write port.
// Only built when SRAM_INIT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | writing INIT_VALUE to address cnt, upstream port ignored
// ST_READY | sweep done, upstream write port passed to the macro
`ifdef SRAM_INIT_EN
module sram_init_sweeper
    import sram_wrap_pkg::*;
#(
    parameter int                 ADDR_W     = 7,
    parameter int                 DEPTH      = 128,
    parameter int                 DATA_W     = 44,
    parameter int                 MASK_W     = 4,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [MASK_W-1:0] w_mask,
    output logic              ready,
    output logic              wr_csb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_din,
    output logic [MASK_W-1:0] wr_mask
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep counter registers; reset restarts the sweep at 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, sweep progress and write-port mux.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        wr_csb  = 1'b1;
        wr_addr = w_addr;
        wr_din  = w_data;
        wr_mask = w_mask;
        case (state_q)
            ST_INIT: begin
                wr_csb  = 1'b0;
                wr_addr = cnt_q;
                wr_din  = INIT_VALUE;
                wr_mask = '1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                ready  = 1'b1;
                wr_csb = ~w_en;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        // The macro must see no access at all while reset is held.
        if (reset) begin
            wr_csb = 1'b1;
        end
    end

endmodule
`endif

// File: rtl/sram_1w1r_init_bypass.sv
// Adapter between a core-side 1w1r memory port (W0_*/R0_*) and an
// OpenRAM 1w1r macro with active-low chip selects. Adds read-during-write
// forwarding on same-address collisions, read-data hold while the read
// port is idle and, when SRAM_INIT_EN is defined, a clearing sweep after
// reset. Without SRAM_INIT_EN the port is ready one cycle after reset and
// the array contents are whatever the macro powered up with.
module sram_1w1r_init_bypass
    import sram_wrap_pkg::*;
#(
    parameter int                 ADDR_W     = 7,
    parameter int                 DEPTH      = 128,
    parameter int                 DATA_W     = 44,
    parameter int                 MASK_W     = 4,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [DATA_W-1:0] W0_data,
    input  logic              W0_en,
    input  logic [MASK_W-1:0] W0_mask,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [DATA_W-1:0] R0_data,
    output logic              mem_csb0,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [DATA_W-1:0] mem_din0,
    output logic [MASK_W-1:0] mem_wmask0,
    output logic              mem_csb1,
    output logic [ADDR_W-1:0] mem_addr1,
    input  logic [DATA_W-1:0] mem_dout1
);

    if (!params_ok(ADDR_W, DEPTH, DATA_W, MASK_W)) begin : g_param_check
        $error("sram_1w1r_init_bypass: illegal ADDR_W/DEPTH/DATA_W/MASK_W combination");
    end

    logic              rd_acc;
    logic              wr_acc;
    logic              coll;
    logic              rd_v_q, rd_v_d;
    logic              coll_v_q, coll_v_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] fwd_sel;
    logic [DATA_W-1:0] fwd_merge;

`ifdef SRAM_INIT_EN
    sram_init_sweeper #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .DATA_W     (DATA_W),
        .MASK_W     (MASK_W),
        .INIT_VALUE (INIT_VALUE)
    ) u_sweeper (
        .clock   (clock),
        .reset   (reset),
        .w_en    (W0_en),
        .w_addr  (W0_addr),
        .w_data  (W0_data),
        .w_mask  (W0_mask),
        .ready   (ready),
        .wr_csb  (mem_csb0),
        .wr_addr (mem_addr0),
        .wr_din  (mem_din0),
        .wr_mask (mem_wmask0)
    );
`else
    logic ready_q, ready_d;

    assign ready_d = 1'b1;

    // Ready goes high on the first clock edge after reset releases.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    // Upstream write port straight to the macro, gated by ready.
    always_comb begin
        ready      = ready_q;
        mem_csb0   = reset | ~(ready_q & W0_en);
        mem_addr0  = W0_addr;
        mem_din0   = W0_data;
        mem_wmask0 = W0_mask;
    end
`endif

    // Accepted accesses, collision detect and macro read-port control.
    always_comb begin
        rd_acc    = ready & R0_en;
        wr_acc    = ready & W0_en;
        coll      = rd_acc & wr_acc & (R0_addr == W0_addr);
        mem_csb1  = reset | ~rd_acc;
        mem_addr1 = R0_addr;
    end

    // Capture the colliding write so it can overlay the macro's old data.
    always_comb begin
        rd_v_d   = rd_acc;
        coll_v_d = coll;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        if (coll) begin
            wdata_d = W0_data;
            mask_d  = W0_mask;
        end
    end

    // Merge forwarded granules with macro data, or replay the held word.
    always_comb begin
        fwd_sel   = '0;
        if (coll_v_q) begin
            fwd_sel = DATA_W'(expand_mask(MAX_MASK_W'(mask_q), DATA_W, MASK_W));
        end
        fwd_merge = (wdata_q & fwd_sel) | (mem_dout1 & ~fwd_sel);
        R0_data   = rd_v_q ? fwd_merge : hold_q;
        hold_d    = R0_data;
    end

    // Read-side pipeline registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_v_q   <= 1'b0;
            coll_v_q <= 1'b0;
            wdata_q  <= '0;
            mask_q   <= '0;
            hold_q   <= '0;
        end else begin
            rd_v_q   <= rd_v_d;
            coll_v_q <= coll_v_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_sram_1w1r_init_bypass.sv
// Bench for sram_1w1r_init_bypass: a behavioural OpenRAM macro (old data
// on unmasked columns, garbage on written columns during a same-address
// read), an array-level reference of what upstream reads must return, a
// per-cycle compare process, and directed vectors with literal checks.
module tb_sram_1w1r_init_bypass;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;
    localparam int DATA_W = 44;
    localparam int MASK_W = 4;
    localparam int G      = DATA_W / MASK_W;

`ifdef SRAM_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    // Without the sweep, pretend the macro powered up clean so reads are defined.
    localparam logic [DATA_W-1:0] POWERUP = INIT_EN ? 44'h5A5A5A5A5A5 : 44'h0;
    localparam logic [DATA_W-1:0] JUNK    = 44'hBADBADBADBA;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ready;
    logic [ADDR_W-1:0] W0_addr = '0;
    logic [DATA_W-1:0] W0_data = '0;
    logic              W0_en   = 1'b0;
    logic [MASK_W-1:0] W0_mask = '0;
    logic [ADDR_W-1:0] R0_addr = '0;
    logic              R0_en   = 1'b0;
    logic [DATA_W-1:0] R0_data;
    logic              mem_csb0;
    logic [ADDR_W-1:0] mem_addr0;
    logic [DATA_W-1:0] mem_din0;
    logic [MASK_W-1:0] mem_wmask0;
    logic              mem_csb1;
    logic [ADDR_W-1:0] mem_addr1;
    logic [DATA_W-1:0] mem_dout1;

    int checks = 0;
    int errors = 0;

    sram_1w1r_init_bypass #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .DATA_W     (DATA_W),
        .MASK_W     (MASK_W),
        .INIT_VALUE ('0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ready      (ready),
        .W0_addr    (W0_addr),
        .W0_data    (W0_data),
        .W0_en      (W0_en),
        .W0_mask    (W0_mask),
        .R0_addr    (R0_addr),
        .R0_en      (R0_en),
        .R0_data    (R0_data),
        .mem_csb0   (mem_csb0),
        .mem_addr0  (mem_addr0),
        .mem_din0   (mem_din0),
        .mem_wmask0 (mem_wmask0),
        .mem_csb1   (mem_csb1),
        .mem_addr1  (mem_addr1),
        .mem_dout1  (mem_dout1)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int g = 0; g < MASK_W; g++) begin
            if (m[g]) r[g*G +: G] = new_w[g*G +: G];
        end
        return r;
    endfunction

    // Behavioural macro: registered read of pre-write contents.
    logic [DATA_W-1:0] macro_mem [DEPTH];
    always @(posedge clock) begin : macro_model
        logic [DATA_W-1:0] rd;
        if (!mem_csb1) begin
            rd = macro_mem[mem_addr1];
            if (!mem_csb0 && mem_addr0 == mem_addr1) rd = merge(rd, JUNK, mem_wmask0);
            mem_dout1 <= rd;
        end
        if (!mem_csb0) macro_mem[mem_addr0] <= merge(macro_mem[mem_addr0], mem_din0, mem_wmask0);
    end

    // Reference: k = edges since reset released, ref_mem = logical contents.
    int                k = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_r = '0;

    function automatic bit model_ready(input int kk);
        return INIT_EN ? (kk >= DEPTH) : (kk >= 1);
    endfunction

    always @(posedge clock) begin : ref_model
        logic [DATA_W-1:0] nxt;
        bit                rdy;
        if (reset) begin
            k     = 0;
            exp_r = '0;
        end else begin
            rdy = model_ready(k);
            if (!rdy && INIT_EN && k < DEPTH) ref_mem[k] = '0;
            nxt = exp_r;
            if (rdy && R0_en) begin
                nxt = ref_mem[R0_addr];
                if (W0_en && W0_addr == R0_addr) nxt = merge(nxt, W0_data, W0_mask);
            end
            if (rdy && W0_en) ref_mem[W0_addr] = merge(ref_mem[W0_addr], W0_data, W0_mask);
            exp_r = nxt;
            if (k < 100000) k++;
        end
    end

    always @(negedge clock) begin : compare
        bit   rdy;
        logic exp_csb0;
        logic exp_csb1;
        if (reset) begin
            check("rst_ready", ready, 0);
            check("rst_csb0", mem_csb0, 1);
            check("rst_csb1", mem_csb1, 1);
            check("rst_r0_data", R0_data, 0);
        end else begin
            rdy      = model_ready(k);
            exp_csb0 = rdy ? ~W0_en : ~INIT_EN;
            exp_csb1 = !(rdy && R0_en);
            check("ready", ready, rdy);
            check("r0_data", R0_data, exp_r);
            check("csb0", mem_csb0, exp_csb0);
            if (!exp_csb0) begin
                check("addr0", mem_addr0, rdy ? W0_addr : k[ADDR_W-1:0]);
                check("din0", mem_din0, rdy ? W0_data : '0);
                check("wmask0", mem_wmask0, rdy ? W0_mask : 4'hF);
            end
            check("csb1", mem_csb1, exp_csb1);
            if (!exp_csb1) check("addr1", mem_addr1, R0_addr);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        W0_en = 1'b0;
        R0_en = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [MASK_W-1:0] m);
        W0_en = 1'b1; W0_addr = a; W0_data = d; W0_mask = m;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        R0_en = 1'b1; R0_addr = a;
    endtask

    task automatic lit(input string name, input logic [DATA_W-1:0] exp);
        check(name, R0_data, exp);
    endtask

    localparam logic [DATA_W-1:0] VAL_A   = 44'h0A0A0A0A0A0;
    localparam logic [DATA_W-1:0] VAL_B   = 44'h0B0B0B0B0B0;
    localparam logic [DATA_W-1:0] VAL_C   = 44'h0C0FFEE0C0C;
    localparam logic [DATA_W-1:0] VAL_5   = 44'hABCDEF01234;
    localparam logic [DATA_W-1:0] VAL_9   = 44'h11111111111;
    localparam logic [DATA_W-1:0] COLL_9  = 44'h111FFD117FF;

    initial begin
        int cyc;
        int sweep_n;
        for (int i = 0; i < DEPTH; i++) begin
            macro_mem[i] = POWERUP;
            ref_mem[i]   = POWERUP;
        end
        repeat (3) step();
        lit("reset_r0_data", '0);

        // Release reset with junk upstream traffic, then reset again mid-sweep.
        wr(7'd77, 44'h123, 4'hF);
        rd(7'd5);
        reset = 1'b0;
        repeat (20) step();
        idle();
        repeat (40) step();
        reset = 1'b1;
        step();
        step();
        wr(7'd77, 44'h456, 4'hF);
        rd(7'd6);
        reset = 1'b0;

        cyc = 0;
        sweep_n = 0;
        while (!ready && cyc < 400) begin
            if (!mem_csb0) sweep_n++;
            if (cyc == 20) idle();
            step();
            cyc++;
        end
        idle();
        check("ready_rise", ready, 1);
        check("sweep_cycles", cyc, INIT_EN ? DEPTH : 1);
        check("sweep_writes", sweep_n, INIT_EN ? DEPTH : 0);

        // Plain write then read, and a swept address.
        wr(7'd5, VAL_5, 4'hF);
        step(); idle(); rd(7'd5);
        step(); lit("rd5", VAL_5); idle(); rd(7'd6);
        step(); lit("rd6_clear", '0); idle();

        // Same-cycle partial write and read of the same address.
        wr(7'd9, VAL_9, 4'hF);
        step(); idle(); wr(7'd9, '1, 4'b0101); rd(7'd9);
        step(); lit("coll9", COLL_9); idle(); rd(7'd9);
        step(); lit("rd9_after", COLL_9); idle();

        // Hold while idle, with writes landing underneath.
        wr(7'd3, VAL_A, 4'hF);
        step(); idle(); rd(7'd3);
        step(); lit("hold_a0", VAL_A); idle();
        for (int i = 0; i < 5; i++) begin
            wr(7'd3, VAL_B, 4'hF);
            step();
            lit("hold_a", VAL_A);
        end
        idle(); rd(7'd3);
        step(); lit("rd3_b", VAL_B); idle();

        // Read then write the same address on the next cycle returns old data.
        rd(7'd5);
        step(); idle(); wr(7'd5, VAL_C, 4'hF); lit("raw_old", VAL_5);
        step(); lit("raw_hold", VAL_5); idle(); rd(7'd5);
        step(); lit("rd5_new", VAL_C); idle();

        // Back-to-back reads with an unrelated partial write alongside.
        rd(7'd3); wr(7'd100, VAL_A, 4'b0010);
        step(); lit("b2b_3", VAL_B); rd(7'd9); idle(); rd(7'd9);
        step(); lit("b2b_9", COLL_9); rd(7'd6);
        step(); lit("b2b_6", '0); rd(7'd5);
        step(); lit("b2b_5", VAL_C); idle();

        // Collision with an empty mask, and full-mask collisions at the ends.
        wr(7'd9, '1, 4'b0000); rd(7'd9);
        step(); lit("coll_nomask", COLL_9); idle();
        wr(7'd127, VAL_B, 4'hF); rd(7'd127);
        step(); lit("coll_127", VAL_B); idle();
        wr(7'd0, VAL_A, 4'b1000); rd(7'd0);
        step(); lit("coll_0", {VAL_A[43:33], 33'h0}); idle();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
